sseg_scroll_buf: RTL
====================

# sseg_scroll_buf

Message buffer and scroller feeding the 4-digit display multiplexer (`led_4_1_mux` stage): accepts hex characters over a valid/ready write port, stores up to DEPTH of them in a circular buffer, and presents a 4-character window as four active-low segment patterns. When the message is longer than four characters and scrolling is enabled, the window steps left or right at a tick rate derived from the system clock. Output array connects directly to the mux's per-digit segment inputs.

## Interface
- TICK_N, 24 — scroll step period = 2^TICK_N i_clk cycles (~6 Hz at 100 MHz)
- DEPTH, 16 — buffer entries; power of 2, >= 8
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wr_valid  in  1  write request
- i_wr_data  in  5  [3:0] hex character, [4] = 1 blank character
- o_wr_ready  out  1  write accepted when valid && ready
- i_clear  in  1  empty buffer (level, sampled each cycle)
- i_run  in  1  scroll enable
- i_dir  in  1  0 = scroll left (window index +1), 1 = scroll right (-1)
- o_len  out  $clog2(DEPTH)+1  stored entries
- o_step  out  1  one-cycle pulse per window step
- o_sseg_n  out  [7:0] x [3:0] unpacked  per-digit segments, active low, bit0=a..bit6=g, bit7=dp; index 3 = leftmost

## Operation
- Storage: entry written at index len; len++ on accepted write. No overwrite; o_wr_ready = (len != DEPTH) && !i_clear.
- i_clear priority over write: next cycle len=0, win=0, state EMPTY; concurrent write dropped.
- Window start win in [0, len-1]; digit 3 shows entry win, digit 2 win+1, digit 1 win+2, digit 0 win+3, all mod len (single conditional subtract; k <= 3 < len).
- States: EMPTY (len==0, all digits 0xFF); STATIC (1<=len<=4: win=0, digits beyond len-1 blank, from digit 3 downward); SCROLL (len>4 && i_run); PAUSE (len>4 && !i_run, win frozen).
- Transitions evaluated every cycle from len/i_run/i_clear; entering STATIC forces win=0; PAUSE->SCROLL resumes from frozen win.
- SCROLL: tick counter (TICK_N bits) zeroed on entry; on all-ones: win steps, o_step pulses. Wrap: left win==len-1 -> 0; right win==0 -> len-1.
- Write during SCROLL/PAUSE: appended, win unchanged, takes effect in modulo next cycle.
- i_dir change mid-scroll applies at next tick; counter not reset.
- Encoding: 0..F to standard patterns ('0'=8'hC0, '1'=8'hF9, '8'=8'h80, 'F'=8'h8E); blank entry = 8'hFF.

## Timing
- Reset (async assert, sync to i_clk by ordinary flop release): len=0, win=0, counter=0, state EMPTY, o_sseg_n all 8'hFF, o_step=0, o_wr_ready=1.
- o_sseg_n registered: reflects buffer/len/win one cycle after they update (write visible 2 cycles after accept).
- o_step asserted the cycle win updates; o_sseg_n shows new window the following cycle.
- First step 2^TICK_N cycles after entering SCROLL, then every 2^TICK_N cycles.
- o_wr_ready, o_len combinational from registered state.

## Configuration
- SSEG_SCROLL_DP_EN defined: in SCROLL/PAUSE, the digit currently showing entry 0 has dp lit (bit7=0) as start-of-message marker.
- Undefined: bit7 forced 1 on all digits in all states.

## Structure
- Package sseg_pkg: state enum (EMPTY, STATIC, SCROLL, PAUSE), SSEG_BLANK = 8'hFF, 16-entry hex segment constant table.
- Sub-module hex_to_sseg (combinational, 5-bit char -> 7 segment bits), instantiated 4 times.

## Test plan
- Reset with TICK_N=4: o_sseg_n all 8'hFF, o_wr_ready=1, o_len=0.
- Write 1,2 -> STATIC: digit3=8'hF9, digit2=8'hA4, digits 1,0=8'hFF; o_step never pulses with i_run=1.
- Write 0..5, i_run=1, i_dir=0 -> o_step every 16 cycles; digit 3 sequence 0,1,2,3,4,5,0 (wraps); with DP_EN, dp on entry-0 digit only.
- Same with i_dir=1 -> digit 3 sequence 0,5,4,3; deassert i_run -> window frozen, no o_step; reassert resumes.
- Fill DEPTH entries -> o_wr_ready=0, 17th write dropped, o_len=16.
- Assert i_clear with concurrent write mid-scroll -> next cycle o_len=0, all digits 8'hFF, write not stored; async reset mid-scroll returns all outputs to reset values immediately.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared scroller state encoding and active-low hex segment table.
package sseg_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_STATIC, ST_SCROLL, ST_PAUSE} state_t;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    // Element i is the pattern for hex digit i (bit0=a .. bit6=g, bit7=dp off).
    localparam logic [15:0][7:0] HEX_SSEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };
endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: 5-bit character (bit4 = blank) to active-low a..g segments.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [4:0] i_char,
    output logic [6:0] o_seg
);
    assign o_seg = i_char[4] ? SSEG_BLANK[6:0] : HEX_SSEG[i_char[3:0]][6:0];
endmodule

// File: rtl/sseg_scroll_buf.sv
// sseg_scroll_buf: circular hex message buffer with a scrolling 4-digit window.
// Define SSEG_SCROLL_DP_EN to light the dp of the digit showing entry 0 while scrolling/paused.
module sseg_scroll_buf
    import sseg_pkg::*;
#(
    parameter int TICK_N = 24,
    parameter int DEPTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_wr_valid,
    input  logic [4:0]                 i_wr_data,
    output logic                       o_wr_ready,
    input  logic                       i_clear,
    input  logic                       i_run,
    input  logic                       i_dir,
    output logic [$clog2(DEPTH):0]     o_len,
    output logic                       o_step,
    output logic [7:0]                 o_sseg_n [3:0]
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [4:0]        r_buf [DEPTH];
    logic [LW-1:0]     r_len, w_len_nxt;
    logic [AW-1:0]     r_win, w_win_nxt, w_last, w_win_step;
    logic [TICK_N-1:0] r_cnt;
    state_t            r_state, w_state_nxt;
    logic              r_step, w_wr, w_tick;

    assign o_wr_ready  = (r_len != LW'(DEPTH)) && !i_clear;
    assign o_len       = r_len;
    assign o_step      = r_step;
    assign w_wr        = i_wr_valid && o_wr_ready;
    assign w_len_nxt   = i_clear ? '0 : r_len + LW'(w_wr);
    assign w_state_nxt = (w_len_nxt == '0) ? ST_EMPTY :
                         (w_len_nxt <= LW'(4)) ? ST_STATIC :
                         i_run ? ST_SCROLL : ST_PAUSE;
    assign w_tick      = (r_state == ST_SCROLL) && (&r_cnt);
    assign w_last      = AW'(r_len - LW'(1));
    assign w_win_step  = i_dir ? ((r_win == '0) ? w_last : r_win - AW'(1))
                               : ((r_win == w_last) ? '0 : r_win + AW'(1));
    assign w_win_nxt   = (w_state_nxt inside {ST_EMPTY, ST_STATIC}) ? '0 :
                         w_tick ? w_win_step : r_win;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_state <= ST_EMPTY;
            r_step  <= 1'b0;
        end else begin
            r_len   <= w_len_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= (r_state == ST_SCROLL && w_state_nxt == ST_SCROLL) ? r_cnt + TICK_N'(1) : '0;
            r_state <= w_state_nxt;
            r_step  <= w_tick && !i_clear;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_buf[r_len[AW-1:0]] <= i_wr_data;
    end

    // Offset k from the window start drives digit 3-k; len > 3 whenever wrap is possible.
    for (genvar k = 0; k < 4; k++) begin : g_dig
        logic [LW-1:0] w_sum;
        logic [AW-1:0] w_idx;
        logic [4:0]    w_char;
        logic [6:0]    w_seg;
        logic          w_dp;
        logic [7:0]    r_seg;
        assign w_sum  = LW'(r_win) + LW'(k);
        assign w_idx  = AW'((w_sum >= r_len) ? w_sum - r_len : w_sum);
        assign w_char = (LW'(k) >= r_len) ? 5'h10 : r_buf[w_idx];
        hex_to_sseg u_hex (.i_char(w_char), .o_seg(w_seg));
`ifdef SSEG_SCROLL_DP_EN
        assign w_dp = !((r_state == ST_SCROLL || r_state == ST_PAUSE) && w_idx == '0);
`else
        assign w_dp = 1'b1;
`endif
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n)
                r_seg <= SSEG_BLANK;
            else
                r_seg <= i_clear ? SSEG_BLANK : {w_dp, w_seg};
        end
        assign o_sseg_n[3-k] = r_seg;
    end
endmodule
